// File: rtl/vga_scan_ctrl.sv
// 640x480@60 scan master: counters, registered row/col addresses, fresh strobe and frame count.
// Pins lag address by PX_LATENCY+1 clocks; free-running with no backpressure (px_in is trusted on schedule).
module vga_scan_ctrl #(
    parameter int          H_ACTIVE    = 640,
    parameter int          H_FP        = 16,
    parameter int          H_SYNC      = 96,
    parameter int          H_BP        = 48,
    parameter int          V_ACTIVE    = 480,
    parameter int          V_FP        = 10,
    parameter int          V_SYNC      = 2,
    parameter int          V_BP        = 33,
    parameter int          PX_LATENCY  = 1,
    parameter int          FRESH_LINES = 2,
    parameter logic [11:0] FG_RGB      = 12'h555,
    parameter logic [11:0] BG_RGB      = 12'hFFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       px_in,
    output logic [8:0] row_addr,
    output logic [9:0] col_addr,
    output logic       fresh,
    output logic [7:0] frame_cnt,
    output logic       hs,
    output logic       vs,
    output logic [3:0] r,
    output logic [3:0] g,
    output logic [3:0] b
);

    localparam logic [9:0] HA       = 10'(H_ACTIVE);
    localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VA       = 10'(V_ACTIVE);
    localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] V_FR_END = 10'(V_ACTIVE + FRESH_LINES);

    logic [9:0]            h_cnt_q, h_cnt_d;
    logic [9:0]            v_cnt_q, v_cnt_d;
    logic [8:0]            row_addr_q, row_addr_d;
    logic [9:0]            col_addr_q, col_addr_d;
    logic                  fresh_q, fresh_d;
    logic [7:0]            frame_cnt_q, frame_cnt_d;
    logic [PX_LATENCY-1:0] act_dly_q, act_dly_d;
    logic [PX_LATENCY-1:0] hs_dly_q, hs_dly_d;
    logic [PX_LATENCY-1:0] vs_dly_q, vs_dly_d;
    logic                  hs_q, hs_d;
    logic                  vs_q, vs_d;
    logic [11:0]           rgb_q, rgb_d;
    logic                  act_raw, hs_raw, vs_raw;

    always_comb begin
        h_cnt_d     = h_cnt_q + 10'd1;
        v_cnt_d     = v_cnt_q;
        fresh_d     = fresh_q;
        frame_cnt_d = frame_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
        end

        // Addresses track the next counter value so they update on the same edge.
        row_addr_d = (v_cnt_d < VA) ? v_cnt_d[8:0] : 9'h1FF;
        col_addr_d = (h_cnt_d < HA) ? h_cnt_d : 10'h3FF;

        if (h_cnt_d == '0 && v_cnt_d == VA) begin
            fresh_d     = 1'b1;
            frame_cnt_d = frame_cnt_q + 8'd1;
        end else if (h_cnt_d == '0 && v_cnt_d == V_FR_END) begin
            fresh_d = 1'b0;
        end

        act_raw = (h_cnt_q < HA) && (v_cnt_q < VA);
        hs_raw  = !((h_cnt_q >= HS_START) && (h_cnt_q < HS_END));
        vs_raw  = !((v_cnt_q >= VS_START) && (v_cnt_q < VS_END));

        act_dly_d[0] = act_raw;
        hs_dly_d[0]  = hs_raw;
        vs_dly_d[0]  = vs_raw;
        for (int i = 1; i < PX_LATENCY; i++) begin
            act_dly_d[i] = act_dly_q[i-1];
            hs_dly_d[i]  = hs_dly_q[i-1];
            vs_dly_d[i]  = vs_dly_q[i-1];
        end

        // Last delay stage is aligned with px_in for the same address.
        hs_d  = hs_dly_q[PX_LATENCY-1];
        vs_d  = vs_dly_q[PX_LATENCY-1];
        rgb_d = act_dly_q[PX_LATENCY-1] ? (px_in ? FG_RGB : BG_RGB) : 12'h000;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt_q     <= '0;
            v_cnt_q     <= '0;
            row_addr_q  <= '0;
            col_addr_q  <= '0;
            fresh_q     <= 1'b0;
            frame_cnt_q <= '0;
            act_dly_q   <= '0;
            hs_dly_q    <= '1;
            vs_dly_q    <= '1;
            hs_q        <= 1'b1;
            vs_q        <= 1'b1;
            rgb_q       <= '0;
        end else begin
            h_cnt_q     <= h_cnt_d;
            v_cnt_q     <= v_cnt_d;
            row_addr_q  <= row_addr_d;
            col_addr_q  <= col_addr_d;
            fresh_q     <= fresh_d;
            frame_cnt_q <= frame_cnt_d;
            act_dly_q   <= act_dly_d;
            hs_dly_q    <= hs_dly_d;
            vs_dly_q    <= vs_dly_d;
            hs_q        <= hs_d;
            vs_q        <= vs_d;
            rgb_q       <= rgb_d;
        end
    end

    assign row_addr  = row_addr_q;
    assign col_addr  = col_addr_q;
    assign fresh     = fresh_q;
    assign frame_cnt = frame_cnt_q;
    assign hs        = hs_q;
    assign vs        = vs_q;
    assign r         = rgb_q[11:8];
    assign g         = rgb_q[7:4];
    assign b         = rgb_q[3:0];

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Bench for vga_scan_ctrl on a shrunken raster; PX_LATENCY=1 and PX_LATENCY=3 instances run side by side.
module tb_vga_scan_ctrl;

    localparam int HA = 10, HFP = 2, HSW = 3, HBP = 1;
    localparam int VA = 5, VFP = 1, VSW = 2, VBP = 2;
    localparam int FL = 2;
    localparam int HT = HA + HFP + HSW + HBP;
    localparam int VT = VA + VFP + VSW + VBP;
    localparam int FRAME = HT * VT;
    localparam int PXC = 4, PXR = 2;
    localparam logic [11:0] FG = 12'h555, BG = 12'hFFF;
    localparam logic [13:0] PIN_RST = {1'b1, 1'b1, 12'h000};

    logic       clk = 1'b0;
    logic       rst;
    logic       px1, px3;
    logic [8:0] row1, row3;
    logic [9:0] col1, col3;
    logic       fr1, fr3, hs1, hs3, vs1, vs3;
    logic [7:0] fc1, fc3;
    logic [3:0] r1, g1, b1, r3, g3, b3;

    always #5 clk = ~clk;

    vga_scan_ctrl #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .PX_LATENCY(1), .FRESH_LINES(FL), .FG_RGB(FG), .BG_RGB(BG)
    ) u_l1 (
        .clk(clk), .rst(rst), .px_in(px1), .row_addr(row1), .col_addr(col1),
        .fresh(fr1), .frame_cnt(fc1), .hs(hs1), .vs(vs1), .r(r1), .g(g1), .b(b1)
    );

    vga_scan_ctrl #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .PX_LATENCY(3), .FRESH_LINES(FL), .FG_RGB(FG), .BG_RGB(BG)
    ) u_l3 (
        .clk(clk), .rst(rst), .px_in(px3), .row_addr(row3), .col_addr(col3),
        .fresh(fr3), .frame_cnt(fc3), .hs(hs3), .vs(vs3), .r(r3), .g(g3), .b(b3)
    );

    int          n_chk = 0;
    int          n_fail = 0;
    int          mh, mv, mfc;
    logic        mf;
    bit          rand_px;
    logic [13:0] exp_q1[$];
    logic [13:0] exp_q3[$];
    logic        pxq1[$];
    logic        pxq3[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (h=%0d v=%0d)", tag, got, exp, mh, mv);
        end
    endtask

    // Pixel the layer model returns for an address; blanking addresses get 1 to prove it is ignored.
    function automatic logic pix(input int h, input int v);
        if (!(h < HA && v < VA)) return 1'b1;
        if (rand_px) return 1'($urandom_range(1, 0));
        return (h == PXC && v == PXR);
    endfunction

    function automatic logic [13:0] exp_pin(input int h, input int v, input logic p);
        logic act, hse, vse;
        act = (h < HA) && (v < VA);
        hse = !(h >= HA + HFP && h < HA + HFP + HSW);
        vse = !(v >= VA + VFP && v < VA + VFP + VSW);
        return {hse, vse, act ? (p ? FG : BG) : 12'h000};
    endfunction

    task automatic model_reset();
        mh = 0; mv = 0; mf = 1'b0; mfc = 0;
        exp_q1.delete(); exp_q3.delete(); pxq1.delete(); pxq3.delete();
        repeat (2) exp_q1.push_back(PIN_RST);
        repeat (4) exp_q3.push_back(PIN_RST);
        px1 = 1'b0; px3 = 1'b0;
    endtask

    // Called at a negedge: check this cycle, drive px for it, advance the model, wait one clock.
    task automatic step();
        logic p;
        logic [8:0] erow;
        logic [9:0] ecol;
        erow = (mv < VA) ? 9'(mv) : 9'h1FF;
        ecol = (mh < HA) ? 10'(mh) : 10'h3FF;
        check("row_l1", row1, erow);
        check("col_l1", col1, ecol);
        check("row_l3", row3, erow);
        check("col_l3", col3, ecol);
        check("fresh_l1", fr1, mf);
        check("fcnt_l1", fc1, mfc);
        check("fresh_l3", fr3, mf);
        check("fcnt_l3", fc3, mfc);
        check("pins_l1", {hs1, vs1, r1, g1, b1}, exp_q1.pop_front());
        check("pins_l3", {hs3, vs3, r3, g3, b3}, exp_q3.pop_front());

        p = pix(mh, mv);
        pxq1.push_back(p);
        exp_q1.push_back(exp_pin(mh, mv, p));
        p = pix(mh, mv);
        pxq3.push_back(p);
        exp_q3.push_back(exp_pin(mh, mv, p));
        px1 = (pxq1.size() > 1) ? pxq1.pop_front() : 1'b0;
        px3 = (pxq3.size() > 3) ? pxq3.pop_front() : 1'b0;

        if (mh == HT - 1) begin
            mh = 0;
            mv = (mv == VT - 1) ? 0 : mv + 1;
        end else begin
            mh = mh + 1;
        end
        if (mh == 0 && mv == VA) begin
            mf = 1'b1;
            mfc = (mfc + 1) % 256;
        end else if (mh == 0 && mv == VA + FL) begin
            mf = 1'b0;
        end
        @(negedge clk);
    endtask

    initial begin
        int hs1_lo, hs3_lo, vs1_lo, vs3_lo, fg1, fg3;
        rst = 1'b1; px1 = 1'b0; px3 = 1'b0; rand_px = 1'b0;
        mh = 0; mv = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_row", row1, 9'h000);
        check("rst_col", col1, 10'h000);
        check("rst_pins", {hs1, vs1, r1, g1, b1, fr1, fc1}, {PIN_RST, 1'b0, 8'h00});
        check("rst_pins_l3", {hs3, vs3, r3, g3, b3, fr3, fc3}, {PIN_RST, 1'b0, 8'h00});
        rst = 1'b0;
        model_reset();

        repeat (2 * FRAME) step();

        hs1_lo = 0; hs3_lo = 0; vs1_lo = 0; vs3_lo = 0; fg1 = 0; fg3 = 0;
        repeat (FRAME) begin
            if (!hs1) hs1_lo++;
            if (!hs3) hs3_lo++;
            if (!vs1) vs1_lo++;
            if (!vs3) vs3_lo++;
            if ({r1, g1, b1} == FG) fg1++;
            if ({r3, g3, b3} == FG) fg3++;
            step();
        end
        check("hs_low_per_frame_l1", hs1_lo, HSW * VT);
        check("hs_low_per_frame_l3", hs3_lo, HSW * VT);
        check("vs_low_per_frame_l1", vs1_lo, VSW * HT);
        check("vs_low_per_frame_l3", vs3_lo, VSW * HT);
        check("fg_count_l1", fg1, 1);
        check("fg_count_l3", fg3, 1);

        rand_px = 1'b1;
        repeat (2 * FRAME) step();
        rand_px = 1'b0;

        for (int i = 0; i < FRAME && !(mh == 7 && mv == 3); i++) step();
        check("mid_reset_point", (mh == 7 && mv == 3), 1);
        rst = 1'b1; px1 = 1'b0; px3 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check("mid_rst_addr", {row1, col1}, 19'h0);
        check("mid_rst_pins", {hs1, vs1, r1, g1, b1}, PIN_RST);
        check("mid_rst_pins_l3", {hs3, vs3, r3, g3, b3}, PIN_RST);

        repeat (FRAME) step();
        check("fcnt_one_frame", fc1, 8'd1);
        repeat (255 * FRAME) step();
        check("fcnt_wrap_l1", fc1, 8'd0);
        check("fcnt_wrap_l3", fc3, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
